// File: rtl/fx_mul_pipe.sv
// fx_mul_pipe: pipelined signed fixed-point multiplier, Q(WIDTH-FRAC).FRAC in and out.
// Stage 1 forms the full 2*WIDTH product, middle stages only delay it, and the
// last stage rounds half toward +inf and range-checks into a WIDTH-bit result.
// With STAGES = 1 the multiply and the round share the single stage.
// Optional feature macro: FXMUL_SAT_EN. When defined, out-of-range results clamp
// and raise ovf. When undefined, results wrap and ovf is tied low.
module fx_mul_pipe #(
  parameter int WIDTH  = 8,
  parameter int FRAC   = 7,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             ovf
);

  localparam int PW = 2 * WIDTH;      // full product width
  localparam int RW = 2 * WIDTH + 1;  // rounding width, one guard bit so the add cannot wrap

  logic                 adv;
  logic [STAGES:1]      vld_q;
  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] b_x;
  logic signed [PW-1:0] mul;
  logic signed [PW-1:0] last_p;  // product entering the final stage
  logic                 last_v;  // valid bit entering the final stage
  logic signed [RW-1:0] p_x;
  logic signed [RW-1:0] r_full;
  logic [WIDTH-1:0]     c_d;
  logic [WIDTH-1:0]     c_q;

  // The whole pipe moves as one; there is no bubble collapsing.
  assign adv       = !vld_q[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES];
  assign c         = c_q;

  assign a_x = PW'($signed(a));
  assign b_x = PW'($signed(b));
  assign mul = a_x * b_x;

  // Valid bits shift one place whenever the pipe advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q[1] <= in_valid;
      for (int i = 2; i <= STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  generate
    if (STAGES == 1) begin : g_one
      assign last_p = mul;
      assign last_v = in_valid;
    end else begin : g_multi
      logic signed [PW-1:0] prod_q [1:STAGES-1];

      // Stage 1 captures the full-precision product of an accepted pair.
      always_ff @(posedge clk) begin
        if (adv && in_valid) begin
          prod_q[1] <= mul;
        end
      end

      for (genvar gi = 2; gi < STAGES; gi++) begin : g_dly
        // Plain delay stage; loads only when a valid item moves into it.
        always_ff @(posedge clk) begin
          if (adv && vld_q[gi-1]) begin
            prod_q[gi] <= prod_q[gi-1];
          end
        end
      end

      assign last_p = prod_q[STAGES-1];
      assign last_v = vld_q[STAGES-1];
    end
  endgenerate

  assign p_x = RW'(last_p);

  generate
    if (FRAC > 0) begin : g_rnd
      localparam logic signed [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (FRAC - 1);
      assign r_full = (p_x + HALF) >>> FRAC;
    end else begin : g_nornd
      assign r_full = p_x;
    end
  endgenerate

`ifdef FXMUL_SAT_EN
  logic [RW-WIDTH:0] r_top;
  logic              ovf_d;
  logic              ovf_q;

  assign r_top = r_full[RW-1:WIDTH-1];
  assign ovf   = ovf_q;

  // In range only when every bit above the result's sign bit matches it.
  always_comb begin
    ovf_d = !((&r_top) || !(|r_top));
    c_d   = r_full[WIDTH-1:0];
    if (ovf_d) begin
      c_d = r_full[RW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Overflow flag travels with the result it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv && last_v) begin
      ovf_q <= ovf_d;
    end
  end
`else
  logic unused_hi;

  // Wrapping result keeps only the low WIDTH bits of the rounded value.
  assign c_d       = r_full[WIDTH-1:0];
  assign unused_hi = ^r_full[RW-1:WIDTH];
  assign ovf       = 1'b0;
`endif

  // Output register loads only when a valid item arrives, so c is stable otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
    end else if (adv && last_v) begin
      c_q <= c_d;
    end
  end

endmodule

// File: tb/tb_fx_mul_pipe.sv
// tb_fx_mul_pipe: directed checks on a STAGES=2 instance plus randomized
// regression on STAGES = 1, 2, 4 instances against a behavioural model.
module tb_fx_mul_pipe;

  localparam int W     = 8;
  localparam int F     = 7;
  localparam int NRAND = 10000;

  typedef struct {
    logic [W:0] res;
    int         acc_cyc;
    int         acc_stl;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", nm, got, exp);
    end
  endtask

  task automatic fail_now(input string nm, input string msg);
    total++;
    bad++;
    $display("FAIL %s: %s", nm, msg);
  endtask

  // Expected {ovf, c} straight from the arithmetic rules, using wide integers.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    longint     p;
    longint     r;
    logic [W-1:0] cv;
    logic       ov;
`ifdef FXMUL_SAT_EN
    longint     hi;
    longint     lo;
`endif
    p = longint'($signed(x)) * longint'($signed(y));
    if (F > 0) r = (p + (longint'(1) <<< (F - 1))) >>> F;
    else       r = p;
    cv = r[W-1:0];
    ov = 1'b0;
`ifdef FXMUL_SAT_EN
    hi = (longint'(1) <<< (W - 1)) - 1;
    lo = -(longint'(1) <<< (W - 1));
    if (r > hi) begin
      cv = hi[W-1:0];
      ov = 1'b1;
    end else if (r < lo) begin
      cv = lo[W-1:0];
      ov = 1'b1;
    end
`endif
    return {ov, cv};
  endfunction

  function automatic logic [W-1:0] pick();
    logic [31:0] rv;
    rv = $urandom;
    case ($urandom_range(0, 7))
      0:       return 8'h80;
      1:       return 8'h7F;
      2:       return 8'h00;
      3:       return 8'hFF;
      default: return rv[W-1:0];
    endcase
  endfunction

  // ---------------- directed instance ----------------
  logic         d_rst, d_iv, d_ir, d_ov, d_or, d_ovf;
  logic [W-1:0] d_a, d_b, d_c;

  fx_mul_pipe #(.WIDTH(W), .FRAC(F), .STAGES(2)) u_dir (
    .clk(clk), .rst(d_rst), .in_valid(d_iv), .in_ready(d_ir), .a(d_a), .b(d_b),
    .out_valid(d_ov), .out_ready(d_or), .c(d_c), .ovf(d_ovf)
  );

  task automatic single(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W:0] exp);
    int lat;
    @(posedge clk); #1;
    d_a = x; d_b = y; d_iv = 1'b1; d_or = 1'b1;
    @(posedge clk); #1;
    d_iv = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!d_ov && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    $display("single %s a=%h b=%h c=%h ovf=%b lat=%0d", nm, x, y, d_c, d_ovf, lat);
    chk({nm, "_lat"}, lat, 2);
    chk({nm, "_res"}, {d_ovf, d_c}, exp);
  endtask

  task automatic backpressure();
    logic [W-1:0] pa [4];
    logic [W-1:0] pb [4];
    logic [W:0]   want [4];
    logic [W:0]   got [$];
    int idx;
    int stalls_seen;
    pa   = '{8'h40, 8'h20, 8'hC0, 8'h7F};
    pb   = '{8'h40, 8'h40, 8'h40, 8'h7F};
    want = '{9'h020, 9'h010, 9'h0E0, 9'h07E};
    idx = 0;
    stalls_seen = 0;
    for (int k = 0; k < 40 && got.size() < 4; k++) begin
      @(posedge clk); #1;
      d_iv = (idx < 4);
      d_a  = pa[(idx < 4) ? idx : 3];
      d_b  = pb[(idx < 4) ? idx : 3];
      d_or = !(got.size() >= 1 && stalls_seen < 3);
      @(negedge clk);
      if (!d_or) begin
        stalls_seen++;
        chk("bp_hold", {d_ov, d_ovf, d_c}, {2'b10, 8'h10});
        chk("bp_in_ready", d_ir, 0);
      end
      if (d_iv && d_ir) idx++;
      if (d_ov && d_or) begin
        got.push_back({d_ovf, d_c});
        $display("bp out #%0d c=%h ovf=%b", got.size(), d_c, d_ovf);
      end
    end
    chk("bp_count", got.size(), 4);
    chk("bp_stalls", stalls_seen, 3);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk("bp_order", got[i], want[i]);
    end
    repeat (3) begin
      @(posedge clk); #1;
      d_iv = 1'b0;
      d_or = 1'b1;
      @(negedge clk);
      chk("bp_no_extra", d_ov, 0);
    end
  endtask

  task automatic reset_mid();
    int n;
    @(posedge clk); #1;
    d_or = 1'b0; d_iv = 1'b1; d_a = 8'h40; d_b = 8'h40;
    @(posedge clk); #1;
    d_a = 8'h20;
    @(negedge clk);
    chk("rst_pre_ready", d_ir, 1);
    @(posedge clk); #1;
    d_iv = 1'b0;
    d_rst = 1'b1;
    @(negedge clk);
    chk("rst_pre_valid", d_ov, 1);
    @(posedge clk); #1;
    d_rst = 1'b0;
    d_or = 1'b1;
    @(negedge clk);
    chk("rst_mid", {d_ov, d_ovf, d_c}, 0);
    $display("reset mid-stream out_valid=%b c=%h", d_ov, d_c);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (d_ov) n++;
    end
    chk("rst_flush", n, 0);
  endtask

  // ---------------- randomized instances ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_rand
    localparam int ST = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);

    logic         rst, iv, ir, ov, ordy, ovf;
    logic [W-1:0] a, b, c;
    item_t        q [$];
    item_t        it;
    int           n_in = 0;
    int           n_out = 0;
    int           cyc = 0;
    int           stall_cnt = 0;
    logic         acc = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W+1:0] snap = '0;

    fx_mul_pipe #(.WIDTH(W), .FRAC(F), .STAGES(ST)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
      .out_valid(ov), .out_ready(ordy), .c(c), .ovf(ovf)
    );

    // Driver: hold a pending pair until it is taken, randomize everything else.
    initial begin
      rst = 1'b1; iv = 1'b0; ordy = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      forever begin
        @(posedge clk); #1;
        if (acc || !iv) begin
          iv = (n_in < NRAND) && ($urandom_range(0, 3) != 0);
          a  = pick();
          b  = pick();
        end
        ordy = ($urandom_range(0, 3) != 0);
      end
    end

    // Monitor: scoreboard in acceptance order, latency and hold checks.
    initial begin
      string nm;
      nm = $sformatf("s%0d", ST);
      forever begin
        @(negedge clk);
        if (!rst) begin
          chk({nm, "_in_ready"}, ir, (!ov || ordy));
          if (prev_stall) chk({nm, "_hold"}, {ov, ovf, c}, snap);
          if (ov && ordy) begin
            if (q.size() == 0) begin
              fail_now({nm, "_extra"}, $sformatf("unexpected output c=0x%0h", c));
            end else begin
              it = q.pop_front();
              chk({nm, "_val"}, {ovf, c}, it.res);
              chk({nm, "_lat"}, cyc - it.acc_cyc, ST + (stall_cnt - it.acc_stl));
              n_out++;
              $display("%s out #%0d c=%h ovf=%b lat=%0d", nm, n_out, c, ovf, cyc - it.acc_cyc);
            end
          end
          if (ov && !ordy) stall_cnt++;
          prev_stall = ov && !ordy;
          snap = {ov, ovf, c};
          acc = iv && ir;
          if (acc) begin
            it.res     = model(a, b);
            it.acc_cyc = cyc;
            it.acc_stl = stall_cnt;
            q.push_back(it);
            n_in++;
          end
          cyc++;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    d_rst = 1'b1; d_iv = 1'b0; d_or = 1'b1; d_a = '0; d_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out", {d_ov, d_ovf, d_c}, 0);
    chk("reset_ready", d_ir, 1);
    @(posedge clk); #1;
    d_rst = 1'b0;

    single("half",    8'h40, 8'h40, 9'h020);
    single("rnd_up",  8'h01, 8'h40, 9'h001);
    single("rnd_dn",  8'h01, 8'h3F, 9'h000);
    single("rnd_neg", 8'hFF, 8'h40, 9'h000);
`ifdef FXMUL_SAT_EN
    single("neg1sq",  8'h80, 8'h80, 9'h17F);
`else
    single("neg1sq",  8'h80, 8'h80, 9'h080);
`endif
    backpressure();
    reset_mid();

    for (int k = 0; k < 60000 && !(g_rand[0].n_out >= NRAND && g_rand[1].n_out >= NRAND &&
                                   g_rand[2].n_out >= NRAND); k++) begin
      @(posedge clk);
    end
    if (!(g_rand[0].n_out >= NRAND && g_rand[1].n_out >= NRAND && g_rand[2].n_out >= NRAND))
      fail_now("rnd_timeout", $sformatf("outputs %0d/%0d/%0d of %0d",
               g_rand[0].n_out, g_rand[1].n_out, g_rand[2].n_out, NRAND));
    repeat (10) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
